// File: rtl/rs_pkg.sv
// rs_pkg: shared GF(2^8) constants, state encoding and elaboration-time field helpers for the RS decoder.
package rs_pkg;
    localparam logic [8:0] GF_POLY = 9'h11D;
    localparam int         T       = 2;
    localparam int         N_DEF   = 255;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN} cf_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] alpha_pow(input int k);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < k % 255; i++) r = xtime(r);
        return r;
    endfunction

    // Inverse as alpha^(255 - log a); zero maps to zero
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        int lg;
        p = 8'h01;
        for (lg = 0; lg < 255 && p != a; lg++) p = xtime(p);
        return a == 8'h00 ? 8'h00 : alpha_pow(255 - lg);
    endfunction
endpackage

// File: rtl/gf2m8_inv.sv
// gf2m8_inv: combinational GF(2^8) inverse from a 256-entry table built at elaboration; 0x00 maps to 0x00.
module gf2m8_inv
    import rs_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] tab [256];

    for (genvar i = 0; i < 256; i++) begin : g_tab
        assign tab[i] = gf_inv(8'(i));
    end

    assign y = tab[a];
endmodule

// File: rtl/gf2m8_multi.sv
// gf2m8_multi: combinational GF(2^8) multiplier reducing by GF_POLY.
module gf2m8_multi
    import rs_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    always_comb begin
        p = 8'h00;
        for (int i = 7; i >= 0; i--) p = xtime(p) ^ (b[i] ? a : 8'h00);
    end
endmodule

// File: rtl/s3_chien_forney.sv
// s3_chien_forney: Chien search over all N positions with Forney error magnitudes (t = 2, GF(2^8)).
// Define S3_ERR_CNT_EN to add out_err_cnt, the number of locator roots found in the block.
module s3_chien_forney
    import rs_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       kes_done,
    input  logic [7:0] rs_lambda0,
    input  logic [7:0] rs_lambda1,
    input  logic [7:0] rs_lambda2,
    input  logic [7:0] rs_omega0,
    input  logic [7:0] rs_omega1,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] out_err,
    output logic       out_last,
    output logic       out_fail
`ifdef S3_ERR_CNT_EN
   ,output logic [1:0] out_err_cnt
`endif
);
    // First test point is x = alpha^-(N-1) = alpha^k
    localparam int         K    = (256 - N) % 255;
    localparam logic [7:0] A_K  = alpha_pow(K);
    localparam logic [7:0] A_2K = alpha_pow(2 * K);

    cf_state_t  state, next_state;
    logic [7:0] l0, l1, l2, w0, om1, inv_l1, t1, t2, w1, cnt;
    logic [7:0] inv_in, p_t1, p_t2, p_w1, s_t1, s_t2, s_w1, err;
    logic [1:0] roots, roots_nxt, deg;
    logic       scan, last, take, hit;

    gf2m8_inv   u_inv (.a(rs_lambda1), .y(inv_in));
    gf2m8_multi u_pt1 (.a(l1),      .b(A_K),    .p(p_t1));
    gf2m8_multi u_pt2 (.a(l2),      .b(A_2K),   .p(p_t2));
    gf2m8_multi u_pw1 (.a(om1),     .b(A_K),    .p(p_w1));
    gf2m8_multi u_st1 (.a(t1),      .b(8'h02),  .p(s_t1));
    gf2m8_multi u_st2 (.a(t2),      .b(8'h04),  .p(s_t2));
    gf2m8_multi u_sw1 (.a(w1),      .b(8'h02),  .p(s_w1));
    gf2m8_multi u_err (.a(w0 ^ w1), .b(inv_l1), .p(err));

    // A new block may be taken in the last scan cycle, chaining straight into LOAD
    always_comb begin
        scan       = state == S_SCAN;
        last       = scan && cnt == 8'd0;
        take       = kes_done && (state == S_IDLE || last);
        hit        = (l0 ^ t1 ^ t2) == 8'h00;
        roots_nxt  = (scan && hit && roots != 2'd3) ? roots + 2'd1 : roots;
        deg        = l2 != 8'h00 ? 2'd2 : l1 != 8'h00 ? 2'd1 : 2'd0;
        next_state = take ? S_LOAD : state == S_LOAD ? S_SCAN : (scan && !last) ? S_SCAN : S_IDLE;
        busy       = state != S_IDLE;
        out_valid  = scan;
        out_last   = last;
        out_err    = (scan && hit) ? err : 8'h00;
        out_fail   = last && (roots_nxt != deg || (l1 == 8'h00 && l2 != 8'h00));
    end

`ifdef S3_ERR_CNT_EN
    assign out_err_cnt = scan ? roots_nxt : roots;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                           <= S_IDLE;
            {l0, l1, l2, w0, om1, inv_l1}   <= '0;
            {t1, t2, w1, cnt}               <= '0;
            roots                           <= '0;
        end else begin
            state <= next_state;
            if (take) begin
                l0     <= rs_lambda0;
                l1     <= rs_lambda1;
                l2     <= rs_lambda2;
                w0     <= rs_omega0;
                om1    <= rs_omega1;
                inv_l1 <= inv_in;
            end
            if (state == S_LOAD) begin
                t1    <= p_t1;
                t2    <= p_t2;
                w1    <= p_w1;
                cnt   <= 8'(N - 1);
                roots <= 2'd0;
            end else if (scan) begin
                t1    <= s_t1;
                t2    <= s_t2;
                w1    <= s_w1;
                cnt   <= cnt - 8'd1;
                roots <= roots_nxt;
            end
        end
    end
endmodule

// File: tb/tb_s3_chien_forney.sv
// tb_s3_chien_forney: directed tests at N = 15 and N = 255, checked every cycle against a
// direct polynomial-evaluation model of the expected stream plus literal magnitude pins.
module tb_s3_chien_forney;
    typedef struct packed {
        logic       busy;
        logic       valid;
        logic       last;
        logic       fail;
        logic [1:0] cnt;
        logic [7:0] err;
    } exp_t;

    localparam int NA      = 15;
    localparam int NB      = 255;
    localparam int CYC_MAX = 4096;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b1;
    logic       kes_a = 1'b0;
    logic       kes_b = 1'b0;
    logic [7:0] lam0 = '0, lam1 = '0, lam2 = '0, om0 = '0, om1 = '0;
    logic       a_busy, a_valid, a_last, a_fail, b_busy, b_valid, b_last, b_fail;
    logic [7:0] a_err, b_err;
    logic [1:0] a_cnt, b_cnt;

    int         n_chk = 0, n_pass = 0, cyc = 0;
    bit         started = 1'b0;
    logic [7:0] gexp [256];
    int         glog [256];
    exp_t       tab [2][CYC_MAX];
    int         nn [2] = '{NA, NB};
    int         free_at [2];
    int         sym_j [2];
    int         got [2][256];
    int         got_fail [2];
    int         got_cnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    s3_chien_forney #(.N(NA)) u_a (
        .clk(clk), .rstn(rstn), .kes_done(kes_a),
        .rs_lambda0(lam0), .rs_lambda1(lam1), .rs_lambda2(lam2),
        .rs_omega0(om0), .rs_omega1(om1),
        .busy(a_busy), .out_valid(a_valid), .out_err(a_err), .out_last(a_last), .out_fail(a_fail)
`ifdef S3_ERR_CNT_EN
        , .out_err_cnt(a_cnt)
`endif
    );

    s3_chien_forney #(.N(NB)) u_b (
        .clk(clk), .rstn(rstn), .kes_done(kes_b),
        .rs_lambda0(lam0), .rs_lambda1(lam1), .rs_lambda2(lam2),
        .rs_omega0(om0), .rs_omega1(om1),
        .busy(b_busy), .out_valid(b_valid), .out_err(b_err), .out_last(b_last), .out_fail(b_fail)
`ifdef S3_ERR_CNT_EN
        , .out_err_cnt(b_cnt)
`endif
    );

`ifndef S3_ERR_CNT_EN
    assign a_cnt = 2'b00;
    assign b_cnt = 2'b00;
`endif

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        return (a == 8'h00 || b == 8'h00) ? 8'h00 : gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic logic [7:0] ginv(logic [7:0] a);
        return a == 8'h00 ? 8'h00 : gexp[(255 - glog[a]) % 255];
    endfunction

    task automatic check(string nm, logic [15:0] g, logic [15:0] w);
        n_chk++;
        if (g === w) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, g, w, cyc);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: evaluate Lambda and Omega at every test point x_j = alpha^-j and schedule the stream
    task automatic issue(int d, int c);
        int n, roots, deg, j;
        logic [7:0] x;
        exp_t e;
        n = nn[d];
        if (c < free_at[d] || c + n + 2 >= CYC_MAX) return;
        free_at[d] = c + n + 1;
        e = '0;
        e.busy = 1'b1;
        tab[d][c + 1] = e;
        roots = 0;
        for (int m = 0; m < n; m++) begin
            j = n - 1 - m;
            x = gexp[(255 - j) % 255];
            e = '0;
            e.busy  = 1'b1;
            e.valid = 1'b1;
            if ((lam0 ^ gm(lam1, x) ^ gm(lam2, gm(x, x))) == 8'h00) begin
                roots = roots < 3 ? roots + 1 : 3;
                if (lam1 != 8'h00) e.err = gm(om0 ^ gm(om1, x), ginv(lam1));
            end
            if (j == 0) begin
                deg    = lam2 != 8'h00 ? 2 : lam1 != 8'h00 ? 1 : 0;
                e.last = 1'b1;
                e.fail = roots != deg || (lam1 == 8'h00 && lam2 != 8'h00);
                e.cnt  = 2'(roots);
            end
            tab[d][c + 2 + m] = e;
        end
    endtask

    task automatic cmp(int d, logic busy, logic valid, logic last, logic fail, logic [1:0] cnt, logic [7:0] err);
        exp_t e;
        string s;
        e = cyc < CYC_MAX ? tab[d][cyc] : '0;
        s = d == 0 ? "a" : "b";
        check({s, ".busy"}, 16'(busy), 16'(e.busy));
        check({s, ".valid"}, 16'(valid), 16'(e.valid));
        check({s, ".last"}, 16'(last), 16'(e.last));
        if (e.valid) check({s, ".err"}, 16'(err), 16'(e.err));
        if (e.last) begin
            check({s, ".fail"}, 16'(fail), 16'(e.fail));
`ifdef S3_ERR_CNT_EN
            check({s, ".cnt"}, 16'(cnt), 16'(e.cnt));
`endif
        end
        if (valid === 1'b1) begin
            if (sym_j[d] >= 0 && sym_j[d] < 256) got[d][sym_j[d]] = int'(err);
            sym_j[d]--;
            if (last === 1'b1) begin
                got_fail[d] = int'(fail);
                got_cnt[d]  = int'(cnt);
                sym_j[d]    = nn[d] - 1;
            end
        end
    endtask

    always @(negedge clk)
        if (started) begin
            cmp(0, a_busy, a_valid, a_last, a_fail, a_cnt, a_err);
            cmp(1, b_busy, b_valid, b_last, b_fail, b_cnt, b_err);
        end

    task automatic prep(int d);
        for (int j = 0; j < 256; j++) got[d][j] = -1;
        got_fail[d] = -1;
        got_cnt[d]  = -1;
        sym_j[d]    = nn[d] - 1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int c = cyc; c < CYC_MAX; c++) tab[d][c] = '0;
            free_at[d] = 0;
            prep(d);
        end
        #1;
        check("rst.a_busy", 16'(a_busy), 16'h0);
        check("rst.a_valid", 16'(a_valid), 16'h0);
        check("rst.a_last", 16'(a_last), 16'h0);
        check("rst.a_fail", 16'(a_fail), 16'h0);
        check("rst.a_err", 16'(a_err), 16'h0);
        check("rst.b_busy", 16'(b_busy), 16'h0);
        check("rst.b_err", 16'(b_err), 16'h0);
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic pulse(int d, logic [7:0] l0, logic [7:0] l1, logic [7:0] l2, logic [7:0] w0, logic [7:0] w1);
        lam0 = l0;
        lam1 = l1;
        lam2 = l2;
        om0  = w0;
        om1  = w1;
        if (d == 0) kes_a = 1'b1;
        else kes_b = 1'b1;
        issue(d, cyc);
        tick(1);
        kes_a = 1'b0;
        kes_b = 1'b0;
    endtask

    // Lambda = (1 + X1 x)(1 + X2 x), Omega = e1 X1 (1 + X2 x) + e2 X2 (1 + X1 x)
    task automatic two_err(int d, int j1, logic [7:0] e1, int j2, logic [7:0] e2);
        logic [7:0] x1, x2;
        x1 = gexp[j1];
        x2 = gexp[j2];
        pulse(d, 8'h01, x1 ^ x2, gm(x1, x2), gm(e1, x1) ^ gm(e2, x2), gm(e1 ^ e2, gm(x1, x2)));
    endtask

    initial begin
        gexp[0] = 8'h01;
        for (int i = 1; i < 256; i++) gexp[i] = {gexp[i-1][6:0], 1'b0} ^ (gexp[i-1][7] ? 8'h1D : 8'h00);
        glog[0] = 0;
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;
        check("pin.mul", 16'(gm(8'h02, 8'h80)), 16'h1D);
        check("pin.inv", 16'(ginv(8'h02)), 16'h8E);
        check("pin.exp25", 16'(gexp[25]), 16'h03);
        check("pin.log1d", 16'(glog[8'h1D]), 16'd8);

        #2;
        started = 1'b1;
        do_reset();

        prep(0);
        pulse(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(NA + 3);
        check("none.fail", 16'(got_fail[0]), 16'd0);
        check("none.err0", 16'(got[0][0]), 16'h00);
        check("none.err14", 16'(got[0][NA-1]), 16'h00);
`ifdef S3_ERR_CNT_EN
        check("none.cnt", 16'(got_cnt[0]), 16'd0);
`endif

        prep(0);
        pulse(0, 8'h01, 8'h01, 8'h00, 8'h05, 8'h00);
        tick(NA + 3);
        check("one.err0", 16'(got[0][0]), 16'h05);
        check("one.err1", 16'(got[0][1]), 16'h00);
        check("one.fail", 16'(got_fail[0]), 16'd0);
`ifdef S3_ERR_CNT_EN
        check("one.cnt", 16'(got_cnt[0]), 16'd1);
`endif

        prep(0);
        pulse(0, 8'h01, 8'h00, 8'h01, 8'h33, 8'h44);
        tick(NA + 3);
        check("degen.fail", 16'(got_fail[0]), 16'd1);
        check("degen.err0", 16'(got[0][0]), 16'h00);

        prep(0);
        two_err(0, 3, 8'h11, 12, 8'hA0);
        tick(NA + 3);
        check("two15.err3", 16'(got[0][3]), 16'h11);
        check("two15.err12", 16'(got[0][12]), 16'hA0);
        check("two15.err0", 16'(got[0][0]), 16'h00);
        check("two15.fail", 16'(got_fail[0]), 16'd0);
`ifdef S3_ERR_CNT_EN
        check("two15.cnt", 16'(got_cnt[0]), 16'd2);
`endif

        prep(1);
        two_err(1, 7, 8'h3C, 200, 8'h81);
        tick(NB + 3);
        check("two255.err7", 16'(got[1][7]), 16'h3C);
        check("two255.err200", 16'(got[1][200]), 16'h81);
        check("two255.err254", 16'(got[1][254]), 16'h00);
        check("two255.fail", 16'(got_fail[1]), 16'd0);
`ifdef S3_ERR_CNT_EN
        check("two255.cnt", 16'(got_cnt[1]), 16'd2);
`endif

        // Ignored pulse mid-scan, then a chained block accepted in the out_last cycle
        prep(0);
        pulse(0, 8'h01, 8'h01, 8'h00, 8'h05, 8'h00);
        tick(4);
        pulse(0, 8'h01, 8'h02, 8'h00, 8'h07, 8'h00);
        tick(NA - 5);
        pulse(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        check("chain.err0", 16'(got[0][0]), 16'h05);
        check("chain.err1", 16'(got[0][1]), 16'h00);
        check("chain.fail", 16'(got_fail[0]), 16'd0);
        prep(0);
        tick(NA + 3);
        check("chain2.err0", 16'(got[0][0]), 16'h00);
        check("chain2.fail", 16'(got_fail[0]), 16'd0);

        prep(0);
        pulse(0, 8'h01, 8'h01, 8'h00, 8'h05, 8'h00);
        tick(3);
        do_reset();
        check("abort.last", 16'(got_fail[0]), 16'hFFFF);
        prep(0);
        two_err(0, 1, 8'h07, 14, 8'h55);
        tick(NA + 3);
        check("post.err1", 16'(got[0][1]), 16'h07);
        check("post.err14", 16'(got[0][14]), 16'h55);
        check("post.fail", 16'(got_fail[0]), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/s3_chien_forney.md
# s3_chien_forney

Error-location and error-value stage of the RS(N, N−4) decoder over GF(2^8), t = 2. It sits directly downstream of the key-equation solver. On the solver's done pulse it captures the error-locator Λ(x) = λ0 + λ1·x + λ2·x² and the error-evaluator Ω(x) = ω0 + ω1·x. It then runs a Chien search over all N codeword positions, one per cycle, and streams a per-symbol error magnitude computed by Forney's formula. The downstream corrector XORs that magnitude into the buffered received symbol.

## Interface
Parameters:
- N, 255: codeword length in symbols; legal range 5..255.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- kes_done  in  1  single-cycle pulse; λ/ω inputs are valid in the same cycle
- rs_lambda0/1/2  in  8 each  Λ coefficients of x^0, x^1, x^2
- rs_omega0/1  in  8 each  Ω coefficients of x^0, x^1
- busy  out  1  high from the capture cycle through the cycle carrying out_last
- out_valid  out  1  one symbol's result this cycle
- out_err  out  8  error magnitude for this symbol; 0x00 means no error
- out_last  out  1  high with the final (N-th) symbol
- out_fail  out  1  decode failure; meaningful only when out_last is high

## Operation
- Field: primitive polynomial 0x11D, α = 0x02. Syndromes use first consecutive root 1, i.e. S_i = r(α^i) for i = 1..4.
- Symbol order: index j runs N−1 down to 0, matching codeword arrival order (highest degree first). Error locator X_j = α^j; Chien test point x_j = α^(−j).
- State machine: IDLE → LOAD → SCAN → IDLE.
- IDLE, kes_done = 1: capture λ0, λ2, ω0, λ1 and inv(λ1); go to LOAD.
- LOAD (1 cycle):
  - t1 = λ1·α^k, t2 = λ2·α^(2k), w1 = ω1·α^k, where k = (256 − N) mod 255.
  - cnt = N−1, roots = 0.
  - go to SCAN.
- SCAN, each cycle:
  - hit = (λ0 ⊕ t1 ⊕ t2 == 0).
  - out_err = hit ? (ω0 ⊕ w1)·inv(λ1) : 0x00.
  - on hit, roots increments, saturating at 3.
  - then t1 ·= α, t2 ·= α², w1 ·= α, cnt −= 1.
  - at cnt == 0: assert out_last, go to IDLE.
- Forney simplification: with first root 1, e_j = Ω(x_j)/Λ'(x_j), and Λ'(x) = λ1 in characteristic 2.
- Expected degree: deg = 2 if λ2 ≠ 0; else 1 if λ1 ≠ 0; else 0.
- out_fail = (roots ≠ deg) or (λ1 == 0 and λ2 ≠ 0).
- When λ1 == 0, hits still count toward roots but out_err is forced to 0x00.
- kes_done while busy is ignored; no capture and no side effect.
- All multiplies are combinational GF(2^8) multipliers. α and α² are fixed-constant multipliers.

## Timing
- kes_done at cycle T → LOAD at T+1 → first out_valid at T+2 → out_last at T+N+1.
- out_valid is continuous for N cycles; there is no backpressure.
- busy is high during T+1..T+N+1.
- A new kes_done is accepted at T+N+1 (same cycle as out_last), since the state returns to IDLE there; first output of the next block follows at T+N+3.
- Reset values: busy, out_valid, out_last, out_fail = 0; out_err = 0x00; all internal registers 0; state IDLE.
- Reset mid-SCAN aborts the block immediately. Outputs return to reset values and no out_last is issued.
- All outputs are registered except that out_err, out_valid and out_last are taken from SCAN-stage registers. There are no combinational paths from inputs to outputs.

## Configuration
- S3_ERR_CNT_EN defined: adds output out_err_cnt [1:0], equal to roots. It is valid with out_last and holds its value until the next capture; reset value 0.
- S3_ERR_CNT_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package rs_pkg holds:
  - GF_POLY = 0x11D and T = 2.
  - The default N.
  - A constant function returning α^k for a given k, used for the LOAD pre-scale constants α^k and α^(2k).
- Reuse the existing gf2m8_multi for all multiplies.
- One new sub-module, gf2m8_inv: a combinational 8-bit inverse using a 256-entry table. Input 0x00 maps to 0x00.

## Test plan
- No errors: λ = (01,00,00), ω = (00,00) → N outputs all 0x00; out_fail = 0; out_err_cnt = 0.
- Single error 0x05 at j = 0: λ = (01,01,00), ω = (05,00) → only the last symbol (out_last cycle) has out_err = 0x05; out_fail = 0; count = 1.
- Degenerate locator: λ = (01,00,01) → all out_err = 0x00 and out_fail = 1 on out_last.
- Two errors: vectors taken from the reference model with N = 255 and with N = 15 → both magnitudes appear at the correct indices; out_fail = 0; count = 2.
- kes_done pulsed mid-SCAN → ignored; the stream length remains N. A second kes_done in the out_last cycle → next stream starts 2 cycles later.
- rstn asserted at SCAN cycle 3 → all outputs 0 immediately; no out_last; the next kes_done is processed normally.
